// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio and frame defaults.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned DBIT_DEFAULT    = 8;
  localparam int unsigned SB_TICK_DEFAULT = 16;
  // Wide enough to count up to a 2-stop-bit period (32 ticks).
  localparam int unsigned TICK_W          = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmitter FSM driven by a 16x oversampling tick; LSB first, idle high.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit after DATA.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEFAULT,
  parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int unsigned BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_e       state;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DBIT-1:0]   shreg;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  logic bit_end;
  logic stop_end;

  assign bit_end  = s_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign stop_end = s_tick && (tick_cnt == TICK_W'(SB_TICK - 1));

  // Outputs are registered alongside the state so tx lines up with the state it encodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            shreg    <= din;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= ^din;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= ST_DATA;
            tx       <= shreg[0];
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_cnt == BIT_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= par;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shreg[1];
            end
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= ST_STOP;
            tx       <= 1'b1;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (stop_end) begin
            tick_cnt     <= '0;
            state        <= ST_IDLE;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b1;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: waveform checked cycle by cycle against a bit-period model.
// Build with UART_TX_PARITY_EN defined to cover the parity frame.
module tb_uart_tx_ctrl;

  localparam int unsigned DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s_tick = 1'b0;
  logic            tx_start = 1'b0;
  logic [DBIT-1:0] din = '0;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after the accept cycle, with p cycles per bit.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int p);
    int idx;
    if (k < 1) return 1'b1;
    idx = (k - 1) / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Sends one frame from IDLE; s_tick every div cycles; optional tx_start pulse at cycle inj_at.
  task automatic run_frame(input logic [7:0] d, input int div, input int inj_at,
                           input logic [7:0] inj_d, input string name);
    int p;
    int len;
    p   = 16 * div;
    len = NBITS * p;
    din      = d;
    tx_start = 1'b1;
    s_tick   = 1'b1;
    for (int k = 1; k <= len + 1; k++) begin
      step();
      check($sformatf("%s_tx@T%0d", name, k), 32'(tx), 32'(exp_tx(k, d, p)));
      check($sformatf("%s_busy@T%0d", name, k), 32'(tx_busy), 32'(k <= len));
      check($sformatf("%s_done@T%0d", name, k), 32'(tx_done_tick), 32'(k == len + 1));
      tx_start = (k == inj_at);
      if (k == inj_at) din = inj_d;
      s_tick = ((k % div) == 0);
    end
  endtask

  initial begin
    // Reset held with a pending request must not launch a frame.
    reset    = 1'b1;
    tx_start = 1'b1;
    din      = 8'hFF;
    s_tick   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done_tick), 32'd0);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_busy", 32'(tx_busy), 32'd0);
      check("post_rst_tx", 32'(tx), 32'd1);
    end

    run_frame(8'hA5, 1, -1, 8'h00, "basic");
    step();
    run_frame(8'h3C, 4, -1, 8'h00, "sparse");
    step();
    run_frame(8'hA5, 1, 50, 8'hFF, "ignore");
    step();

    // Back-to-back frame accepted in the done cycle, then aborted by reset.
    run_frame(8'hA5, 1, FRAME_LEN + 1, 8'h01, "b2b");
    step();
    tx_start = 1'b0;
    s_tick   = 1'b1;
    check("b2b_second_start_tx", 32'(tx), 32'd0);
    check("b2b_second_busy", 32'(tx_busy), 32'd1);
    for (int k = FRAME_LEN + 3; k <= FRAME_LEN + 39; k++) step();
    check("b2b_bit1_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done_tick), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      check("abort_no_done", 32'(tx_done_tick), 32'd0);
      check("abort_no_resume", 32'(tx), 32'd1);
    end

    // Without ticks the frame stalls in START.
    din      = 8'h55;
    tx_start = 1'b1;
    s_tick   = 1'b0;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("stall_tx", 32'(tx), 32'd0);
    check("stall_busy", 32'(tx_busy), 32'd1);
    check("stall_done", 32'(tx_done_tick), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("stall_abort_busy", 32'(tx_busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    step();
    run_frame(8'h07, 1, -1, 8'h00, "parity");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
